counter_sched_ctrl: RTL and testbench

Scheduler that shares one 4-bit loadable up-counter (free-running, +1 per clk, synchronous load) between NUM_REQ requesters as an interval timer. Each requester asks for an interval of 1..16 cycles. A round-robin arbiter grants one requester at a time. The block loads the counter with a start value, watches for terminal count 4'hF, then pulses done to the granted requester. It sits beside the counter and drives its load and load_data pins.

---
 rtl/counter_sched_pkg.sv | 40 ++++
 rtl/counter_sched_ctrl_rr_arbiter.sv | 55 +++++
 rtl/counter_sched_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_counter_sched_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
//   Shared definitions for the interval-timer scheduler that time-shares one
//   4-bit loadable up-counter between several requesters.
//
//   Contents:
//     CNT_W          - width of the shared counter (fixed at 4)
//     TERMINAL_COUNT - counter value that marks the end of an interval
//     state_t        - scheduler FSM states
//     len_to_start() - converts an interval length (0 encodes 16) into the
//                      value the counter must be loaded with so that it
//                      reaches TERMINAL_COUNT after (len-1) increments
//     idx_width()    - width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package counter_sched_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] TERMINAL_COUNT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Start value is the two's complement of the length modulo 16. A length of
  // 0 (meaning 16) therefore starts at 0 and needs 15 increments to hit 4'hF.
  function automatic logic [CNT_W-1:0] len_to_start(input logic [CNT_W-1:0] len);
    return ~len + CNT_W'(1);
  endfunction

  // A single requester still needs a 1-bit index so ports never collapse to
  // zero width.
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/counter_sched_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Starting one position above
//   i_rr_ptr and wrapping modulo NUM_REQ, it selects the first asserted
//   request bit. Nothing is granted while i_enable is low.
//
//   Ports:
//     i_req     [NUM_REQ]  request vector
//     i_rr_ptr  [IDX_W]    index of the most recently served requester
//     i_enable  [1]        arbitration allowed this cycle
//     o_grant   [NUM_REQ]  one-hot winner (zero if none)
//     o_idx     [IDX_W]    binary index of the winner (0 if none)
//     o_valid   [1]        a winner was found
// -----------------------------------------------------------------------------
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    // NOTE: every output gets a default before the search loop, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_found = 1'b0;
    w_cand  = i_rr_ptr;
    // Walk NUM_REQ candidates: rr_ptr+1, rr_ptr+2, ... wrapping at LAST_IDX.
    // The pointer itself is visited last, so a lone requester is re-granted.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + IDX_W'(1);
      if (i_enable && !w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/counter_sched_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sched_ctrl
//   Shares one free-running 4-bit loadable up-counter between NUM_REQ
//   requesters as an interval timer. A round-robin arbiter picks a requester
//   in IDLE; the block then loads the counter with a start value derived from
//   that requester's length, waits for the counter to reach 4'hF and pulses
//   done to the winner. abort cancels the interval in LOAD or RUN and pulses
//   aborted instead. All outputs are registered.
//
//   Ports:
//     clk            [1]           rising-edge clock
//     reset          [1]           asynchronous active-high reset
//     req            [NUM_REQ]     request levels, held until done/aborted
//     len            [NUM_REQ*4]   per-requester lengths, slice i = len[4i+3:4i],
//                                  0 encodes 16
//     abort          [1]           cancel the in-flight interval
//     gnt            [NUM_REQ]     one-hot grant, LOAD through DONE
//     done           [NUM_REQ]     one-cycle completion pulse
//     aborted        [NUM_REQ]     one-cycle cancellation pulse
//     busy           [1]           FSM is not in IDLE
//     cnt_load       [1]           counter synchronous load strobe
//     cnt_load_data  [CNT_W]       counter load value
//     cnt_value      [CNT_W]       counter output
// -----------------------------------------------------------------------------
module counter_sched_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       aborted,
  output logic                     busy,
  output logic                     cnt_load,
  output logic [CNT_W-1:0]         cnt_load_data,
  input  logic [CNT_W-1:0]         cnt_value
);

  import counter_sched_pkg::*;

  localparam int IDX_W = idx_width(NUM_REQ);

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;       // requester currently being served
  logic [IDX_W-1:0]   r_rr_ptr;    // last requester served (arbiter start point)
  logic [NUM_REQ-1:0] r_gnt;       // one-hot of r_idx while the interval is live
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_aborted;
  logic               r_busy;
  logic               r_cnt_load;
  logic [CNT_W-1:0]   r_cnt_load_data;   // holds the start value L

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_arb_en;
  logic [CNT_W-1:0]   w_len_sel;
  logic               w_terminal;

  assign w_arb_en   = (r_state == IDLE);
  assign w_terminal = (cnt_value == TERMINAL_COUNT);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .i_enable (w_arb_en),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // Length of the winning requester, selected by its one-hot grant.
  always_comb begin
    w_len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_len_sel = len[i*CNT_W +: CNT_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  //   IDLE -> LOAD : a request is pending; latch winner and start value
  //   LOAD -> RUN  : counter is loaded at the end of LOAD
  //   RUN  -> DONE : counter reached terminal count
  //   DONE -> IDLE : done pulse delivered
  //   LOAD/RUN -> IDLE on abort (abort wins over terminal count)
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of statement
  // order inside the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_rr_ptr        <= IDX_W'(NUM_REQ - 1);   // req[0] has top priority
      r_gnt           <= '0;
      r_done          <= '0;
      r_aborted       <= '0;
      r_busy          <= 1'b0;
      r_cnt_load      <= 1'b0;
      r_cnt_load_data <= '0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      r_done     <= '0;
      r_aborted  <= '0;
      r_cnt_load <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_idx           <= w_idx;
            r_gnt           <= w_grant;
            r_busy          <= 1'b1;
            r_cnt_load      <= 1'b1;
            r_cnt_load_data <= len_to_start(w_len_sel);
            r_state         <= LOAD;
          end
        end

        LOAD: begin
          if (abort) begin
            r_aborted <= r_gnt;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_rr_ptr  <= r_idx;
            r_state   <= IDLE;
          end else begin
            r_state <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            r_aborted <= r_gnt;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_rr_ptr  <= r_idx;
            r_state   <= IDLE;
          end else if (w_terminal) begin
            // Grant stays up through DONE; done mirrors it for one cycle.
            r_done  <= r_gnt;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= r_idx;
          r_state  <= IDLE;
        end

        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt           = r_gnt;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign busy          = r_busy;
  assign cnt_load      = r_cnt_load;
  assign cnt_load_data = r_cnt_load_data;

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_sched_ctrl
//   Bench for counter_sched_ctrl. Provides the shared 4-bit loadable counter,
//   a transaction-level reference model (owner, effective length and age of
//   the live interval), a per-cycle compare process, a set of directed
//   scenarios with hand-computed expectations, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_counter_sched_ctrl;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  logic                     clk   = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req   = '0;
  logic [NUM_REQ*CNT_W-1:0] len   = '0;
  logic                     abort = 1'b0;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       aborted;
  logic                     busy;
  logic                     cnt_load;
  logic [CNT_W-1:0]         cnt_load_data;
  logic [CNT_W-1:0]         cnt_value;

  int n_total = 0;
  int n_bad   = 0;

  counter_sched_ctrl #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .len           (len),
    .abort         (abort),
    .gnt           (gnt),
    .done          (done),
    .aborted       (aborted),
    .busy          (busy),
    .cnt_load      (cnt_load),
    .cnt_load_data (cnt_load_data),
    .cnt_value     (cnt_value)
  );

  always #5 clk = ~clk;

  // Shared counter: free-running, synchronous load, never reset.
  initial cnt_value = 4'($urandom);
  always @(posedge clk) cnt_value <= cnt_load ? cnt_load_data : cnt_value + 4'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. e_* are the outputs expected during the current cycle.
  // An interval is described by its owner, effective length (1..16) and age:
  // age 0 is the load cycle, ages 1..len are counting, age len+1 is the done
  // cycle. Abort is honoured at ages 0..len.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] e_gnt      = '0;
  logic [NUM_REQ-1:0] e_done     = '0;
  logic [NUM_REQ-1:0] e_aborted  = '0;
  logic               e_busy     = 1'b0;
  logic               e_load     = 1'b0;
  logic [CNT_W-1:0]   e_load_data = '0;
  logic               e_data_zero = 1'b1;   // no load since reset
  bit                 m_active   = 1'b0;
  int                 m_owner    = 0;
  int                 m_len      = 0;
  int                 m_age      = 0;
  int                 m_rr       = NUM_REQ - 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active    = 1'b0;
      m_rr        = NUM_REQ - 1;
      e_gnt       = '0;
      e_done      = '0;
      e_aborted   = '0;
      e_busy      = 1'b0;
      e_load      = 1'b0;
      e_load_data = '0;
      e_data_zero = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (e_gnt[i] && !e_done[i] && !req[i])
          $error("protocol: req[%0d] dropped while granted", i);
      end
      e_done    = '0;
      e_aborted = '0;
      e_load    = 1'b0;
      if (!m_active) begin
        if (req != '0) begin
          bit found;
          found = 1'b0;
          for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (m_rr + k) % NUM_REQ;
            if (!found && req[cand]) begin
              found   = 1'b1;
              m_owner = cand;
            end
          end
          m_len       = (len[m_owner*CNT_W +: CNT_W] == 0) ? 16 : int'(len[m_owner*CNT_W +: CNT_W]);
          m_active    = 1'b1;
          m_age       = 0;
          e_load      = 1'b1;
          e_load_data = 4'((16 - m_len) % 16);
          e_data_zero = 1'b0;
        end
      end else if (m_age <= m_len && abort) begin
        e_aborted[m_owner] = 1'b1;
        m_active = 1'b0;
        m_rr     = m_owner;
      end else if (m_age == m_len + 1) begin
        m_active = 1'b0;
        m_rr     = m_owner;
      end else begin
        m_age++;
        if (m_age == m_len + 1) e_done[m_owner] = 1'b1;
      end
      e_gnt  = m_active ? (NUM_REQ'(1) << m_owner) : '0;
      e_busy = m_active;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("done", 32'(done), 32'(e_done));
    check("aborted", 32'(aborted), 32'(e_aborted));
    check("busy", 32'(busy), 32'(e_busy));
    check("cnt_load", 32'(cnt_load), 32'(e_load));
    if (e_load)
      check("cnt_load_data", 32'(cnt_load_data), 32'(e_load_data));
    else if (e_data_zero)
      check("cnt_load_data_rst", 32'(cnt_load_data), 32'h0);
    check("exclusive", {28'h0, $onehot0(gnt), $onehot0(done), $onehot0(aborted), ~|(done & aborted)}, 32'hF);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int oh2idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int d1;
    int n_rise;
    int n_dn;
    int rise_k[5];
    int rise_i[5];
    int done_k[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [NUM_REQ-1:0] prev_g;

    // ---- 1: single requester, len=3 -> start 4'hD, done at c+5 ----
    do_reset();
    check("t1_reset_busy", 32'(busy), 32'h0);
    check("t1_reset_gnt", 32'(gnt), 32'h0);
    req = 4'b0001;
    len = 16'h0003;
    tick();
    check("t1_load", 32'(cnt_load), 32'h1);
    check("t1_load_data", 32'(cnt_load_data), 32'hD);
    check("t1_gnt_load", 32'(gnt), 32'h1);
    d1 = -1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (k <= 5) check("t1_gnt_hold", 32'(gnt), 32'h1);
      if (done != '0 && d1 < 0) begin
        d1 = k;
        check("t1_done_bit", 32'(done), 32'h1);
        check("t1_busy_at_done", 32'(busy), 32'h1);
        req = '0;
      end else if (d1 >= 0 && k == d1 + 1) begin
        check("t1_busy_after", 32'(busy), 32'h0);
      end
    end
    check("t1_done_cycle", d1, 5);

    // ---- 2: all request, len=1, round robin 0,1,2,3,0 ----
    do_reset();
    len    = 16'h1111;
    req    = 4'hF;
    n_rise = 0;
    n_dn   = 0;
    prev_g = '0;
    for (int n = 0; n < 5; n++) begin
      rise_k[n] = -1;
      rise_i[n] = -1;
      done_k[n] = -1;
    end
    for (int k = 1; k <= 40 && n_dn < 5; k++) begin
      tick();
      if (gnt != '0 && prev_g == '0 && n_rise < 5) begin
        rise_k[n_rise] = k;
        rise_i[n_rise] = oh2idx(gnt);
        n_rise++;
      end
      if (done != '0) begin
        done_k[n_dn] = k;
        n_dn++;
        if (n_dn == 5) req = '0;
      end
      prev_g = gnt;
    end
    check("t2_grants", n_rise, 5);
    check("t2_dones", n_dn, 5);
    for (int n = 0; n < 5; n++) begin
      check("t2_order", rise_i[n], exp_order[n]);
      check("t2_grant_time", rise_k[n], 1 + 4 * n);
      check("t2_done_latency", done_k[n], rise_k[n] + 2);
    end

    // ---- 3: len=0 (16) on requester 1, counter walks 0..F ----
    do_reset();
    req = 4'b0010;
    len = 16'h1101;
    tick();
    check("t3_load_data", 32'(cnt_load_data), 32'h0);
    check("t3_gnt", 32'(gnt), 32'h2);
    d1 = -1;
    for (int k = 2; k <= 21; k++) begin
      tick();
      if (k <= 17) check("t3_cnt_seq", 32'(cnt_value), k - 2);
      if (done != '0 && d1 < 0) begin
        d1 = k;
        check("t3_done_bit", 32'(done), 32'h2);
        req = '0;
      end
    end
    check("t3_done_cycle", d1, 18);

    // ---- 4: abort 3 cycles into RUN, then priority starts at req[3] ----
    do_reset();
    req = 4'b0100;
    len = 16'h1811;
    tick();                 // LOAD
    tick();                 // RUN 1
    tick();                 // RUN 2
    tick();                 // RUN 3
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_aborted", 32'(aborted), 32'h4);
    check("t4_no_done", 32'(done), 32'h0);
    check("t4_gnt_clear", 32'(gnt), 32'h0);
    check("t4_busy_clear", 32'(busy), 32'h0);
    req = 4'b1111;
    tick();
    check("t4_next_gnt", 32'(gnt), 32'h8);

    // ---- 5: reset 2 cycles into RUN, then req[1] wins ----
    do_reset();
    req = 4'b1000;
    len = 16'h8111;
    tick();                 // LOAD
    tick();                 // RUN 1
    tick();                 // RUN 2
    reset = 1'b1;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'h0);
    check("t5_rst_done", 32'(done), 32'h0);
    check("t5_rst_aborted", 32'(aborted), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_load", 32'(cnt_load), 32'h0);
    req = 4'b0110;
    len = 16'h1111;
    tick();
    reset = 1'b0;
    tick();
    check("t5_first_gnt", 32'(gnt), 32'h2);

    // ---- 6: abort in the same cycle as terminal count ----
    do_reset();
    req = 4'b0001;
    len = 16'h1113;
    tick();                 // LOAD
    tick();                 // RUN, cnt=D
    tick();                 // RUN, cnt=E
    tick();                 // RUN, cnt=F
    check("t6_cnt_terminal", 32'(cnt_value), 32'hF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_aborted", 32'(aborted), 32'h1);
    check("t6_no_done", 32'(done), 32'h0);
    req = '0;
    tick();
    check("t6_still_no_done", 32'(done), 32'h0);

    // ---- Randomized traffic against the model ----
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req[i]) begin
            if ((e_done[i] || e_aborted[i]) && $urandom_range(0, 1) == 1) req[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            len[i*CNT_W +: CNT_W] = 4'($urandom);
            req[i] = 1'b1;
          end
        end
        abort = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    abort = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
